cpu_mem_responder: RTL and testbench

Memory-side responder for the CPU's two valid/ready channels: the instruction request/response channel and the data request/response channel. It holds a single-port word-addressed RAM shared by both channels, arbitrates between them, applies a configurable access latency and returns read data through registered valid/ready responses. It is used as the memory model under the CPU in simulation and as the on-chip memory in FPGA builds.

---
 rtl/cpu_mem_responder.sv | 200 ++++++++++++++++++++
 tb/tb_cpu_mem_responder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU fetch and data channels. It uses one shared word RAM, and data requests win arbitration.
// Optional build macro MEM_RAND_LAT_EN: LFSR-driven access latency instead of the fixed LAT.
module cpu_mem_responder #(
  parameter int ADDR_W    = 14,
  parameter int LAT       = 2,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        Inst_Req_Valid,
  output logic        Inst_Req_Ready,
  output logic [31:0] Instruction,
  output logic        Inst_Valid,
  input  logic        Inst_Ready,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  input  logic        MemRead,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready,
  output logic [31:0] inst_req_cnt,
  output logic [31:0] load_cnt,
  output logic [31:0] store_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, BUSY, RESP_I, RESP_D} state_t;
  typedef enum logic [1:0] {KIND_FETCH, KIND_LOAD, KIND_STORE} kind_t;

  logic [31:0] mem [0:DEPTH-1];

  state_t            state_reg, state_next;
  kind_t             kind_reg, kind_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [3:0]        wstrb_reg, wstrb_next;
  logic [31:0]       inst_cnt_reg, inst_cnt_next;
  logic [31:0]       load_cnt_reg, load_cnt_next;
  logic [31:0]       store_cnt_reg, store_cnt_next;
  logic [31:0]       instruction_reg, read_data_reg;
  logic              mem_we, rd_inst_en, rd_load_en;
  logic              data_req, accept;
  logic [3:0]        lat_load;

  // Only the word index is decoded; the rest of each address aliases.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{PC[31:ADDR_W+2], PC[1:0], Address[31:ADDR_W+2], Address[1:0]};

  assign data_req       = MemRead | MemWrite;
  assign Mem_Req_Ready  = (state_reg == IDLE) & data_req;
  assign Inst_Req_Ready = (state_reg == IDLE) & Inst_Req_Valid & ~data_req;
  assign accept         = Mem_Req_Ready | Inst_Req_Ready;

`ifdef MEM_RAND_LAT_EN
  logic [15:0] lfsr_reg, lfsr_next;
  logic [4:0]  lat_sum;

  assign lat_sum   = {1'b0, lfsr_reg[3:0]} + 5'(LAT);
  assign lat_load  = lat_sum[4] ? 4'hF : lat_sum[3:0];
  assign lfsr_next = accept ? {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]}
                            : lfsr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= 16'hACE1;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end
`else
  assign lat_load = 4'(LAT);
`endif

  always_comb begin
    state_next     = state_reg;
    kind_next      = kind_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    inst_cnt_next  = inst_cnt_reg;
    load_cnt_next  = load_cnt_reg;
    store_cnt_next = store_cnt_reg;
    mem_we         = 1'b0;
    rd_inst_en     = 1'b0;
    rd_load_en     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          idx_next   = data_req ? Address[ADDR_W+1:2] : PC[ADDR_W+1:2];
          wdata_next = Write_data;
          wstrb_next = Write_strb;
          cnt_next   = lat_load;
          state_next = BUSY;
          // A simultaneous MemRead/MemWrite is a plain store.
          if (MemWrite) begin
            kind_next      = KIND_STORE;
            store_cnt_next = store_cnt_reg + 32'd1;
          end else if (MemRead) begin
            kind_next     = KIND_LOAD;
            load_cnt_next = load_cnt_reg + 32'd1;
          end else begin
            kind_next     = KIND_FETCH;
            inst_cnt_next = inst_cnt_reg + 32'd1;
          end
        end
      end
      BUSY: begin
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          case (kind_reg)
            KIND_STORE: begin
              mem_we     = ~rst;
              state_next = IDLE;
            end
            KIND_LOAD: begin
              rd_load_en = 1'b1;
              state_next = RESP_D;
            end
            default: begin
              rd_inst_en = 1'b1;
              state_next = RESP_I;
            end
          endcase
        end
      end
      RESP_I: begin
        if (Inst_Ready) begin
          state_next = IDLE;
        end
      end
      RESP_D: begin
        if (Read_data_Ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      kind_reg        <= KIND_FETCH;
      cnt_reg         <= 4'd0;
      idx_reg         <= '0;
      wdata_reg       <= 32'd0;
      wstrb_reg       <= 4'd0;
      inst_cnt_reg    <= 32'd0;
      load_cnt_reg    <= 32'd0;
      store_cnt_reg   <= 32'd0;
      instruction_reg <= 32'd0;
      read_data_reg   <= 32'd0;
    end else begin
      state_reg     <= state_next;
      kind_reg      <= kind_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      inst_cnt_reg  <= inst_cnt_next;
      load_cnt_reg  <= load_cnt_next;
      store_cnt_reg <= store_cnt_next;
      if (rd_inst_en) begin
        instruction_reg <= mem[idx_reg];
      end
      if (rd_load_en) begin
        read_data_reg <= mem[idx_reg];
      end
    end
  end

  // RAM contents survive reset; the write enable is already masked by rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_reg[b]) begin
          mem[idx_reg][8*b +: 8] <= wdata_reg[8*b +: 8];
        end
      end
    end
  end

  assign Instruction     = instruction_reg;
  assign Read_data       = read_data_reg;
  assign Inst_Valid      = (state_reg == RESP_I);
  assign Read_data_Valid = (state_reg == RESP_D);
  assign inst_req_cnt    = inst_cnt_reg;
  assign load_cnt        = load_cnt_reg;
  assign store_cnt       = store_cnt_reg;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: expected read words are queued at request time and popped on each response.
module tb_cpu_mem_responder;
  localparam int ADDR_W = 14;
  localparam int LAT    = 2;
  localparam int BUDGET = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready;
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        MemRead;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;
  logic [31:0] inst_req_cnt, load_cnt, store_cnt;

  always #5 clk = ~clk;

  cpu_mem_responder #(.ADDR_W(ADDR_W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
    .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
    .Address(Address), .MemWrite(MemWrite), .Write_data(Write_data), .Write_strb(Write_strb),
    .MemRead(MemRead), .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data),
    .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
    .inst_req_cnt(inst_req_cnt), .load_cnt(load_cnt), .store_cnt(store_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model [int];
  logic [31:0] exp_i_q[$];
  logic [31:0] exp_d_q[$];
  logic [31:0] exp_inst_cnt = 0, exp_load_cnt = 0, exp_store_cnt = 0;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'((1 << ADDR_W) - 1));
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (model.exists(widx(a))) return model[widx(a)];
    return 32'hxxxxxxxx;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // kind: 0 fetch, 1 load, 2 store, 3 load+store together
  task automatic send_req(input logic [1:0] kind, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic ok);
    logic [31:0] merged;
    case (kind)
      2'd0: begin PC = addr; Inst_Req_Valid = 1'b1; end
      2'd1: begin Address = addr; MemRead = 1'b1; end
      default: begin
        Address = addr; MemWrite = 1'b1; Write_data = data; Write_strb = strb;
        if (kind == 2'd3) MemRead = 1'b1;
      end
    endcase
    ok = 1'b0;
    for (int n = 0; n < BUDGET; n++) begin
      #1;
      if ((kind == 2'd0) ? Inst_Req_Ready : Mem_Req_Ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
      case (kind)
        2'd0: begin exp_i_q.push_back(model_rd(addr)); exp_inst_cnt++; end
        2'd1: begin exp_d_q.push_back(model_rd(addr)); exp_load_cnt++; end
        default: begin
          merged = model.exists(widx(addr)) ? model[widx(addr)] : 32'h0;
          for (int b = 0; b < 4; b++) if (strb[b]) merged[8*b +: 8] = data[8*b +: 8];
          model[widx(addr)] = merged;
          exp_store_cnt++;
        end
      endcase
    end
    $display("req kind=%0d addr=%08h data=%08h strb=%h accepted=%0b", kind, addr, data, strb, ok);
    Inst_Req_Valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic wait_resp(input logic is_inst, output logic [31:0] d, output logic ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    d = 32'hxxxxxxxx;
    for (int n = 0; n < BUDGET; n++) begin
      if (is_inst ? Inst_Valid : Read_data_Valid) begin
        ok = 1'b1;
        d = is_inst ? Instruction : Read_data;
        break;
      end
      tick();
      cyc++;
    end
  endtask

  task automatic accept_resp(input logic is_inst);
    if (is_inst) Inst_Ready = 1'b1; else Read_data_Ready = 1'b1;
    tick();
    Inst_Ready = 1'b0;
    Read_data_Ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    for (int pass = 0; pass < 2; pass++) begin
      n_cmp++; if ({Inst_Req_Ready, Mem_Req_Ready, Inst_Valid, Read_data_Valid} !== 4'b0) begin
        n_err++; $display("FAIL reset_flags: got %b want 0000", {Inst_Req_Ready, Mem_Req_Ready, Inst_Valid, Read_data_Valid}); end
      n_cmp++; if ({Instruction, Read_data} !== 64'h0) begin
        n_err++; $display("FAIL reset_data: got %08h/%08h want 0/0", Instruction, Read_data); end
      n_cmp++; if ({inst_req_cnt, load_cnt, store_cnt} !== 96'h0) begin
        n_err++; $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0", inst_req_cnt, load_cnt, store_cnt); end
      rst = 1'b0;
      tick();
    end
    $display("reset done");
  endtask

  task automatic test_fetch;
    logic ok; logic [31:0] d, e; int cyc;
    send_req(2'd2, 32'h0, 32'h00000013, 4'hF, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL fetch_seed_store: got timeout want accept"); end
    send_req(2'd0, 32'h0, 32'h0, 4'h0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL fetch_accept: got timeout want Inst_Req_Ready=1"); end
    wait_resp(1'b1, d, ok, cyc);
    e = (exp_i_q.size() > 0) ? exp_i_q.pop_front() : 32'hxxxxxxxx;
    $display("fetch resp data=%08h after %0d cycles", d, cyc);
    n_cmp++; if (ok !== 1'b1 || cyc != LAT + 1) begin
      n_err++; $display("FAIL fetch_latency: got %0d cycles (valid=%0b) want %0d", cyc, ok, LAT + 1); end
    n_cmp++; if (d !== e || d !== 32'h00000013) begin
      n_err++; $display("FAIL fetch_data: got %08h want %08h", d, e); end
    accept_resp(1'b1);
    n_cmp++; if (Inst_Valid !== 1'b0) begin n_err++; $display("FAIL fetch_idle: got Inst_Valid=%0b want 0", Inst_Valid); end
    n_cmp++; if (inst_req_cnt !== exp_inst_cnt) begin
      n_err++; $display("FAIL fetch_cnt: got %0d want %0d", inst_req_cnt, exp_inst_cnt); end
  endtask

  task automatic test_store_load;
    logic ok; logic [31:0] d, e; int cyc; logic spurious;
    send_req(2'd2, 32'h100, 32'h00000000, 4'hF, ok);
    send_req(2'd2, 32'h100, 32'hAABBCCDD, 4'b0101, ok);
    send_req(2'd1, 32'h100, 32'h0, 4'h0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL load_accept: got timeout want accept"); end
    wait_resp(1'b0, d, ok, cyc);
    e = (exp_d_q.size() > 0) ? exp_d_q.pop_front() : 32'hxxxxxxxx;
    $display("load resp data=%08h after %0d cycles", d, cyc);
    n_cmp++; if (d !== e || d !== 32'h00BB00DD) begin
      n_err++; $display("FAIL strb_load_data: got %08h want %08h", d, e); end
    accept_resp(1'b0);
    send_req(2'd3, 32'h104, 32'h12345678, 4'hF, ok);
    spurious = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      if (Read_data_Valid !== 1'b0) spurious = 1'b1;
      tick();
    end
    n_cmp++; if (spurious !== 1'b0) begin n_err++; $display("FAIL both_no_resp: got Read_data_Valid=1 want 0"); end
    n_cmp++; if ({load_cnt, store_cnt} !== {exp_load_cnt, exp_store_cnt}) begin
      n_err++; $display("FAIL both_cnt: got load=%0d store=%0d want %0d/%0d", load_cnt, store_cnt, exp_load_cnt, exp_store_cnt); end
    send_req(2'd1, 32'h104, 32'h0, 4'h0, ok);
    wait_resp(1'b0, d, ok, cyc);
    e = (exp_d_q.size() > 0) ? exp_d_q.pop_front() : 32'hxxxxxxxx;
    n_cmp++; if (d !== e || d !== 32'h12345678) begin
      n_err++; $display("FAIL both_store_data: got %08h want %08h", d, e); end
    accept_resp(1'b0);
  endtask

  task automatic test_priority;
    logic ok; logic [31:0] d, e; int cyc;
    PC = 32'h0; Inst_Req_Valid = 1'b1; Address = 32'h104; MemRead = 1'b1;
    #1;
    n_cmp++; if ({Mem_Req_Ready, Inst_Req_Ready} !== 2'b10) begin
      n_err++; $display("FAIL prio_ready: got mem=%0b inst=%0b want 1/0", Mem_Req_Ready, Inst_Req_Ready); end
    @(posedge clk); #1;
    MemRead = 1'b0;
    exp_d_q.push_back(model_rd(32'h104)); exp_load_cnt++;
    wait_resp(1'b0, d, ok, cyc);
    e = (exp_d_q.size() > 0) ? exp_d_q.pop_front() : 32'hxxxxxxxx;
    $display("prio load resp data=%08h", d);
    n_cmp++; if (ok !== 1'b1 || d !== e) begin n_err++; $display("FAIL prio_load_data: got %08h want %08h", d, e); end
    n_cmp++; if (inst_req_cnt !== exp_inst_cnt) begin
      n_err++; $display("FAIL prio_fetch_early: got inst_req_cnt=%0d want %0d", inst_req_cnt, exp_inst_cnt); end
    accept_resp(1'b0);
    #1;
    n_cmp++; if (Inst_Req_Ready !== 1'b1) begin n_err++; $display("FAIL prio_fetch_next: got Inst_Req_Ready=%0b want 1", Inst_Req_Ready); end
    @(posedge clk); #1;
    Inst_Req_Valid = 1'b0;
    exp_i_q.push_back(model_rd(32'h0)); exp_inst_cnt++;
    wait_resp(1'b1, d, ok, cyc);
    e = (exp_i_q.size() > 0) ? exp_i_q.pop_front() : 32'hxxxxxxxx;
    n_cmp++; if (ok !== 1'b1 || d !== e) begin n_err++; $display("FAIL prio_fetch_data: got %08h want %08h", d, e); end
    accept_resp(1'b1);
  endtask

  task automatic test_back_to_back_stall;
    logic ok; logic [31:0] d, e, held; int cyc; logic stall_bad;
    send_req(2'd1, 32'h100, 32'h0, 4'h0, ok);
    wait_resp(1'b0, d, ok, cyc);
    e = (exp_d_q.size() > 0) ? exp_d_q.pop_front() : 32'hxxxxxxxx;
    held = d;
    PC = 32'h0; Inst_Req_Valid = 1'b1;
    stall_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (Read_data_Valid !== 1'b1 || Read_data !== held || Inst_Req_Ready !== 1'b0) stall_bad = 1'b1;
      @(posedge clk); #1;
    end
    $display("stall load data=%08h held=%08h", Read_data, held);
    n_cmp++; if (stall_bad !== 1'b0) begin n_err++; $display("FAIL stall_hold: got valid=%0b data=%08h want 1/%08h", Read_data_Valid, Read_data, held); end
    n_cmp++; if (d !== e) begin n_err++; $display("FAIL stall_data: got %08h want %08h", d, e); end
    n_cmp++; if (inst_req_cnt !== exp_inst_cnt) begin n_err++; $display("FAIL stall_accept: got %0d want %0d", inst_req_cnt, exp_inst_cnt); end
    accept_resp(1'b0);
    send_req(2'd0, 32'h0, 32'h0, 4'h0, ok);
    wait_resp(1'b1, d, ok, cyc);
    e = (exp_i_q.size() > 0) ? exp_i_q.pop_front() : 32'hxxxxxxxx;
    n_cmp++; if (ok !== 1'b1 || d !== e) begin n_err++; $display("FAIL stall_fetch: got %08h want %08h", d, e); end
    accept_resp(1'b1);
  endtask

  task automatic test_alias;
    logic ok; logic [31:0] d, e; int cyc;
    send_req(2'd1, 32'h00010100, 32'h0, 4'h0, ok);
    wait_resp(1'b0, d, ok, cyc);
    e = (exp_d_q.size() > 0) ? exp_d_q.pop_front() : 32'hxxxxxxxx;
    $display("alias load data=%08h", d);
    n_cmp++; if (d !== e || d !== 32'h00BB00DD) begin n_err++; $display("FAIL alias_data: got %08h want %08h", d, e); end
    accept_resp(1'b0);
    n_cmp++; if ({inst_req_cnt, load_cnt, store_cnt} !== {exp_inst_cnt, exp_load_cnt, exp_store_cnt}) begin
      n_err++; $display("FAIL counters: got %0d/%0d/%0d want %0d/%0d/%0d", inst_req_cnt, load_cnt, store_cnt,
                        exp_inst_cnt, exp_load_cnt, exp_store_cnt); end
  endtask

  task automatic test_reset_mid_store;
    logic ok; logic [31:0] d, e; int cyc;
    Address = 32'h100; Write_data = 32'hDEADBEEF; Write_strb = 4'hF; MemWrite = 1'b1;
    #1;
    n_cmp++; if (Mem_Req_Ready !== 1'b1) begin n_err++; $display("FAIL abort_accept: got %0b want 1", Mem_Req_Ready); end
    @(posedge clk); #1;
    MemWrite = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    $display("reset during store commit cycle");
    n_cmp++; if ({Inst_Valid, Read_data_Valid, Instruction, Read_data, inst_req_cnt, load_cnt, store_cnt} !== '0) begin
      n_err++; $display("FAIL abort_outputs: got valid=%0b%0b data=%08h/%08h cnt=%0d/%0d/%0d want all 0",
                        Inst_Valid, Read_data_Valid, Instruction, Read_data, inst_req_cnt, load_cnt, store_cnt); end
    rst = 1'b0;
    exp_inst_cnt = 0; exp_load_cnt = 0; exp_store_cnt = 0;
    exp_i_q.delete(); exp_d_q.delete();
    tick();
    send_req(2'd1, 32'h100, 32'h0, 4'h0, ok);
    wait_resp(1'b0, d, ok, cyc);
    e = (exp_d_q.size() > 0) ? exp_d_q.pop_front() : 32'hxxxxxxxx;
    n_cmp++; if (d !== e || d !== 32'h00BB00DD) begin n_err++; $display("FAIL abort_no_commit: got %08h want %08h", d, e); end
    accept_resp(1'b0);
    n_cmp++; if (load_cnt !== 32'd1 || store_cnt !== 32'd0) begin
      n_err++; $display("FAIL abort_cnt: got load=%0d store=%0d want 1/0", load_cnt, store_cnt); end
  endtask

  initial begin
    rst = 1'b1; PC = 0; Inst_Req_Valid = 0; Inst_Ready = 0; Address = 0; MemWrite = 0;
    Write_data = 0; Write_strb = 0; MemRead = 0; Read_data_Ready = 0;
    test_reset();
    test_fetch();
    test_store_load();
    test_priority();
    test_back_to_back_stall();
    test_alias();
    test_reset_mid_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
